serial_word_packer: RTL and testbench



---
 rtl/serial_pkg.sv | 36 +++
 rtl/word_fifo.sv | 83 ++++++++
 rtl/serial_word_packer.sv | 119 +++++++++++
 tb/tb_serial_word_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial word packer: word/entry types, defaults, derived control states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: WIDTH_DEF/DEPTH_DEF defaults, word_t, entry_t {data, parity},
// packer/occupancy state enums and the word parity helper.
package serial_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;

    typedef logic [WIDTH_DEF-1:0] word_t;

    typedef struct packed {
        word_t data;
        logic  parity;
    } entry_t;

    // Packer control state, decoded from the bit counter and bit_valid.
    typedef enum logic {
        PK_FILL,
        PK_COMPLETE
    } pack_state_t;

    // FIFO control state, decoded from occupancy.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

    function automatic logic word_parity_f(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small FIFO of entry_t records for completed words.
// Latency: push at edge N is visible on head after edge N when the FIFO was empty.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, rst (async active-high), push/push_data, pop, head (registered storage),
// empty, full, count (log2(DEPTH)+1 bits).
module word_fifo
    import serial_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic          empty,
    output logic          full,
    output logic [PW-1:0] count
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        last_q, last_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == PW'(DEPTH));
    assign count = count_q;

    // Once drained, the head keeps showing the last entry that was read out
    // rather than whatever stale slot the read pointer now points at.
    assign head = empty ? last_q : mem_q[rd_ptr_q[PW-2:0]];

    always_comb begin
        mem_d    = mem_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);

        if (pop_ok) begin
            last_d   = mem_q[rd_ptr_q[PW-2:0]];
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[PW-2:0]] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + PW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream MSB-first into parity-tagged words and buffers them for a valid/ready consumer.
// Latency: last bit accepted at edge N -> word_valid with that word after edge N (empty FIFO).
// Backpressure: full FIFO without a same-cycle pop drops the new word and sets sticky overflow.
//
// Ports: clk, rst (async active-high); bit_in/bit_valid serial input; align restarts the word;
// word_out/word_parity/word_valid/word_ready output handshake; overflow sticky, clear_ovf clears it.
module serial_word_packer
    import serial_pkg::*;
#(
    // Storage type entry_t is sized by WIDTH_DEF; change that localparam to resize.
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             align,
    output logic [WIDTH-1:0] word_out,
    output logic             word_parity,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] new_word;
    pack_state_t      pack_state;
    occ_state_t       occ_state;
    logic             push_req, push_ok, pop, drop;
    entry_t           push_entry, head;
    logic             fifo_empty, fifo_full;
    logic [PW-1:0]    fifo_count;

    always_comb begin
        if (fifo_count == '0) begin
            occ_state = OCC_EMPTY;
        end else if (fifo_count == PW'(DEPTH)) begin
            occ_state = OCC_FULL;
        end else begin
            occ_state = OCC_PARTIAL;
        end
    end

    assign word_valid = !fifo_empty;
    assign pop        = word_ready && (occ_state != OCC_EMPTY);

    always_comb begin
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        new_word = {sr_q[WIDTH-2:0], bit_in};

        // align wins over a same-cycle bit, so that bit can never complete a word.
        pack_state = (bit_valid && !align && cnt_q == CW'(WIDTH - 1)) ? PK_COMPLETE : PK_FILL;
        push_req   = (pack_state == PK_COMPLETE);

        if (align) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (bit_valid) begin
            sr_d  = new_word;
            cnt_d = push_req ? '0 : cnt_q + CW'(1);
        end

        // A pop in the same cycle frees the slot even when the FIFO is full.
        push_ok = push_req && (!fifo_full || pop);
        drop    = push_req && !push_ok;

        push_entry.data   = new_word;
        push_entry.parity = word_parity_f(new_word);

        // A drop coinciding with clear_ovf must not be lost.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            ovf_q <= ovf_d;
        end
    end

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign word_out    = head.data;
    assign word_parity = head.parity;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer: vector table plus directed corner sequences.
// Latency: checks the one-cycle word_valid latency and the async reset response.
// Backpressure: exercises ready low, overflow drop, and full-with-simultaneous-pop.
module tb_serial_word_packer;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       align;
    logic [7:0] word_out;
    logic       word_parity;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;
    logic       clear_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] w;
        logic       p;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [7:0] data;
        bit         gaps;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    serial_word_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .align       (align),
        .word_out    (word_out),
        .word_parity (word_parity),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every word handed over on the handshake is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got word 0x%0h with nothing expected", word_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_word", {24'd0, word_out}, {24'd0, e.w});
                chk("sb_parity", {31'd0, word_parity}, {31'd0, e.p});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            if (gaps && i != 0) tick();
        end
    endtask

    task automatic expect_word(input logic [7:0] d, input logic p);
        exp_t e;
        e.w = d;
        e.p = p;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{data: 8'hB2, gaps: 1'b0, exp_par: 1'b0};
        vecs[1] = '{data: 8'hFF, gaps: 1'b1, exp_par: 1'b0};
        vecs[2] = '{data: 8'h5A, gaps: 1'b0, exp_par: 1'b0};
        vecs[3] = '{data: 8'h81, gaps: 1'b1, exp_par: 1'b0};
        vecs[4] = '{data: 8'h07, gaps: 1'b0, exp_par: 1'b1};

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; align = 1'b0;
        word_ready = 1'b0; clear_ovf = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_word", {24'd0, word_out}, 32'd0);
        chk("rst_parity", {31'd0, word_parity}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        // Vector table: latency, one-cycle pulse, gapped bit_valid.
        word_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            expect_word(vecs[v].data, vecs[v].exp_par);
            send_word(vecs[v].data, vecs[v].gaps);
            chk("lat_valid", {31'd0, word_valid}, 32'd1);
            chk("lat_word", {24'd0, word_out}, {24'd0, vecs[v].data});
            tick();
            chk("pulse_end", {31'd0, word_valid}, 32'd0);
        end

        // Overflow with ready held low.
        word_ready = 1'b0;
        expect_word(8'h01, 1'b1);
        expect_word(8'h02, 1'b1);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        send_word(8'h03, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("hold_word", {24'd0, word_out}, 32'h01);
        chk("hold_par", {31'd0, word_parity}, 32'd1);
        word_ready = 1'b1;
        repeat (3) tick();
        chk("ovf_drain_valid", {31'd0, word_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with a pop in the same cycle as the completing bit.
        word_ready = 1'b0;
        expect_word(8'h10, 1'b1);
        expect_word(8'h20, 1'b1);
        expect_word(8'h30, 1'b0);
        send_word(8'h10, 1'b0);
        send_word(8'h20, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h30 >> i));
        word_ready = 1'b1;
        send_bit(1'b0);
        chk("full_pop_no_ovf", {31'd0, overflow}, 32'd0);
        repeat (3) tick();
        chk("full_pop_drained", {31'd0, word_valid}, 32'd0);

        // align discards a partial word and the bit that arrives with it.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        align = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        align = 1'b0; bit_valid = 1'b0;
        chk("align_no_word", {31'd0, word_valid}, 32'd0);
        expect_word(8'h5A, 1'b0);
        send_word(8'h5A, 1'b0);
        chk("align_word", {24'd0, word_out}, 32'h5A);
        repeat (3) tick();

        // Asynchronous reset mid-word with buffered words and overflow set.
        word_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        send_word(8'h55, 1'b0);
        send_word(8'h66, 1'b0);
        chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, word_valid}, 32'd0);
        chk("async_ovf", {31'd0, overflow}, 32'd0);
        chk("async_word", {24'd0, word_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        word_ready = 1'b1;
        expect_word(8'hC3, 1'b0);
        send_word(8'hC3, 1'b0);
        chk("post_rst_word", {24'd0, word_out}, 32'hC3);
        chk("post_rst_par", {31'd0, word_parity}, 32'd0);
        repeat (3) tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
